// File: rtl/fp_sqrt_pkg.sv
// Shared types and constants for the single-precision square-root front end.
// Operand classes decide whether the core is used or the result is produced directly.
package fp_sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_PINF,
        CLS_NAN,
        CLS_NEG,
        CLS_NORMAL
    } cls_t;

    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [31:0] QUIET_BIT = 32'h0040_0000;

endpackage

// File: rtl/fp_sqrt_classify.sv
// Combinational screening of an IEEE-754 single operand for the sqrt front end.
// Produces the operand class plus the ready-made result and invalid flag for special cases.
module fp_sqrt_classify
    import fp_sqrt_pkg::*;
#(
    parameter logic [31:0] NAN_VAL = 32'h7FC0_0000
) (
    input  logic [31:0] in_data,
    output cls_t        cls,
    output logic [31:0] result,
    output logic        invalid
);

    logic        sign;
    logic [7:0]  expo;
    logic [22:0] frac;

    assign sign = in_data[31];
    assign expo = in_data[30:23];
    assign frac = in_data[22:0];

    // NaN must be tested before the sign so that negative NaNs stay NaNs.
    always_comb begin
        cls     = CLS_NORMAL;
        result  = in_data;
        invalid = 1'b0;
        if (expo == 8'h00) begin
            cls    = CLS_ZERO;
            result = {sign, 31'b0};
        end else if (expo == EXP_MAX && frac == 23'd0 && !sign) begin
            cls    = CLS_PINF;
            result = in_data;
        end else if (expo == EXP_MAX && frac != 23'd0) begin
            cls     = CLS_NAN;
            result  = in_data | QUIET_BIT;
            invalid = ~frac[22];
        end else if (sign) begin
            cls     = CLS_NEG;
            result  = NAN_VAL;
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/fp_sqrt_issue_ctrl.sv
// Sequencer in front of a fixed-latency sqrt core: accept, screen, issue, wait, respond.
// Special operands are answered directly; one operand is in flight at a time.
module fp_sqrt_issue_ctrl #(
    parameter int          LATENCY = 30,
    parameter logic [31:0] QNAN    = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_bypass,
    output logic        sqrt_start,
    output logic [31:0] sqrt_data_i,
    input  logic [31:0] sqrt_data_o
);

    import fp_sqrt_pkg::*;

    localparam int             CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY - 1);

    state_t        state;
    logic [CW-1:0] counter;

    cls_t          cls;
    logic [31:0]   cls_result;
    logic          cls_invalid;

    fp_sqrt_classify #(
        .NAN_VAL (QNAN)
    ) u_classify (
        .in_data (in_data),
        .cls     (cls),
        .result  (cls_result),
        .invalid (cls_invalid)
    );

    // Ready is the only decoded output; it is forced low while reset is held.
    assign in_ready = (state == ST_IDLE) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            counter     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_bypass  <= 1'b0;
            sqrt_start  <= 1'b0;
            sqrt_data_i <= '0;
        end else begin
            sqrt_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (cls == CLS_NORMAL) begin
                            sqrt_data_i <= in_data;
                            sqrt_start  <= 1'b1;
                            state       <= ST_ISSUE;
                        end else begin
                            out_data    <= cls_result;
                            out_invalid <= cls_invalid;
                            out_bypass  <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    // The core samples start on this edge; its result lands LATENCY edges later.
                    counter <= CNT_LOAD;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (counter == '0) begin
                        out_data    <= sqrt_data_o;
                        out_invalid <= 1'b0;
                        out_bypass  <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_issue_ctrl.sv
// Directed bench for fp_sqrt_issue_ctrl with a behavioural fixed-latency core model.
// The model drives a valid result only on the one cycle it is due, so early/late capture shows up.
module tb_fp_sqrt_issue_ctrl;

    localparam int L = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_bypass;
    logic        sqrt_start;
    logic [31:0] sqrt_data_i;
    logic [31:0] sqrt_data_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int stab_err = 0;
    int core_cnt = 0;
    logic [31:0] core_op = '0;

    fp_sqrt_issue_ctrl #(
        .LATENCY (L),
        .QNAN    (32'h7FC0_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_invalid (out_invalid),
        .out_bypass  (out_bypass),
        .sqrt_start  (sqrt_start),
        .sqrt_data_i (sqrt_data_i),
        .sqrt_data_o (sqrt_data_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
        case (x)
            32'h4080_0000: return 32'h4000_0000;
            32'h4110_0000: return 32'h4040_0000;
            32'h4180_0000: return 32'h4080_0000;
            32'h4010_0000: return 32'h3FC0_0000;
            default:       return 32'h1234_5678;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sqrt_start) start_cnt <= start_cnt + 1;
    end

    // Core model: start sampled on an edge, result valid for the edge L cycles later only.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_cnt <= 0;
        end else if (sqrt_start) begin
            core_cnt <= L;
            core_op  <= sqrt_data_i;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (sqrt_data_i !== core_op) stab_err <= stab_err + 1;
        end
    end

    assign sqrt_data_o = (core_cnt == 1) ? sqrt_ref(core_op) : 32'hDEAD_BEEF;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; acc is the index of the accepting posedge.
    task automatic send(input logic [31:0] d, output int acc, input string tag);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(32'(n < 200), 32'd1, {tag, "_accept_timeout"});
        @(negedge clk);
        acc      = cyc;
        in_valid = 1'b0;
        in_data  = 32'hA5A5_A5A5;
    endtask

    // lat counts edges from the accept edge to the edge that raises out_valid (0 = same edge).
    task automatic recv(input logic [31:0] exp_d, input logic exp_inv, input logic exp_byp,
                        input int exp_lat, input int acc, input int hold, input string tag);
        int n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(32'(n < 400), 32'd1, {tag, "_valid_timeout"});
        chk(32'(cyc - acc), 32'(exp_lat), {tag, "_latency"});
        chk(out_data, exp_d, {tag, "_data"});
        chk({31'b0, out_invalid}, {31'b0, exp_inv}, {tag, "_invalid"});
        chk({31'b0, out_bypass}, {31'b0, exp_byp}, {tag, "_bypass"});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({out_valid, in_ready, out_data}, {1'b1, 1'b0, exp_d}, {tag, "_hold"});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({31'b0, out_valid}, 32'd0, {tag, "_valid_drop"});
        chk({31'b0, in_ready}, 32'd1, {tag, "_ready_back"});
    endtask

    task automatic run_op(input logic [31:0] d, input logic [31:0] exp_d, input logic exp_inv,
                          input logic exp_byp, input int hold, output int acc, input string tag);
        int s0;
        s0 = start_cnt;
        send(d, acc, tag);
        recv(exp_d, exp_inv, exp_byp, exp_byp ? 0 : L + 1, acc, hold, tag);
        chk(32'(start_cnt - s0), exp_byp ? 32'd0 : 32'd1, {tag, "_starts"});
    endtask

    initial begin
        int a0;
        int a1;
        int s0;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk({out_valid, out_invalid, out_bypass, sqrt_start, in_ready}, 32'd0, "rst_flags");
        chk(out_data, 32'd0, "rst_out_data");
        chk(sqrt_data_i, 32'd0, "rst_sqrt_data_i");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk({31'b0, in_ready}, 32'd1, "rst_ready");

        // Normal operand through the core.
        run_op(32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0, 0, a0, "sqrt4");

        // Specials answered directly.
        run_op(32'hC080_0000, 32'h7FC0_0000, 1'b1, 1'b1, 0, a0, "neg4");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 0, a0, "negzero");
        run_op(32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b1, 0, a0, "pinf");
        run_op(32'h7F80_0001, 32'h7FC0_0001, 1'b1, 1'b1, 0, a0, "snan");
        run_op(32'h7FC0_0000, 32'h7FC0_0000, 1'b0, 1'b1, 0, a0, "qnan");
        run_op(32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1'b1, 0, a0, "ninf");
        run_op(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 0, a0, "subnorm");

        // Output backpressure on a normal operand.
        run_op(32'h4110_0000, 32'h4040_0000, 1'b0, 1'b0, 10, a0, "bp_sqrt9");

        // Reset in the middle of the wait.
        s0 = start_cnt;
        send(32'h4080_0000, a0, "mid");
        repeat (10) @(negedge clk);
        chk(32'(start_cnt - s0), 32'd1, "mid_started");
        rst = 1'b1;
        #1;
        chk({out_valid, out_invalid, out_bypass, sqrt_start, in_ready}, 32'd0, "mid_rst_flags");
        chk(out_data, 32'd0, "mid_rst_out_data");
        chk(sqrt_data_i, 32'd0, "mid_rst_sqrt_data_i");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk({31'b0, in_ready}, 32'd1, "mid_ready");
        run_op(32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0, 0, a0, "after_rst");

        // Back-to-back normal operands.
        run_op(32'h4180_0000, 32'h4080_0000, 1'b0, 1'b0, 0, a0, "b2b_sqrt16");
        run_op(32'h4010_0000, 32'h3FC0_0000, 1'b0, 1'b0, 0, a1, "b2b_sqrt2p25");
        chk(32'(a1 - a0), 32'(L + 3), "b2b_spacing");

        chk(32'(stab_err), 32'd0, "operand_stable");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
